// File: rtl/gsensor_pkg.sv
// Shared definitions for the ADXL345 SPI responder model: register map,
// device ID and frame FSM encoding.
package gsensor_pkg;

    localparam int unsigned ADDR_W = 6;

    localparam logic [ADDR_W-1:0] ADDR_DEVID       = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [ADDR_W-1:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [ADDR_W-1:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [ADDR_W-1:0] ADDR_INT_MAP     = 6'h2F;
    localparam logic [ADDR_W-1:0] ADDR_INT_SOURCE  = 6'h30;
    localparam logic [ADDR_W-1:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [ADDR_W-1:0] ADDR_DATAX0      = 6'h32;
    localparam logic [ADDR_W-1:0] ADDR_DATAX1      = 6'h33;
    localparam logic [ADDR_W-1:0] ADDR_DATAY0      = 6'h34;
    localparam logic [ADDR_W-1:0] ADDR_DATAY1      = 6'h35;
    localparam logic [ADDR_W-1:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [ADDR_W-1:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [7:0] DEVID = 8'hE5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA
    } state_t;

endpackage

// File: rtl/gsensor_spi_slave_sync_edge.sv
// Multi-stage synchronizer for one SPI pad input, with rise/fall strobes
// decoded from the last synchronizer stage.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Strobes are combinational so the consumer acts one cycle after the last stage.
    assign o_level  = r_sync[SYNC_STAGES-1];
    assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall_c = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/gsensor_spi_slave.sv
// ADXL345-style 3-wire SPI responder: command decode, config register file,
// frame-consistent X/Y/Z snapshot and data-ready interrupt on INT2.
module gsensor_spi_slave
    import gsensor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID_VAL   = DEVID,
    parameter logic [7:0]  BW_RATE_RST = 8'h0A
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSPI_CSN,
    input  logic        iSPI_CLK,
    input  logic        iSPI_SDI,
    output logic        oSPI_SDO,
    output logic        oSPI_SDO_OE,
    input  logic [15:0] iX_DATA,
    input  logic [15:0] iY_DATA,
    input  logic [15:0] iZ_DATA,
    input  logic        iSAMPLE_VLD,
    output logic        oINT2,
    output logic        oMEASURE,
    output logic [7:0]  oBW_RATE,
    output logic [7:0]  oDATA_FORMAT
);

    logic w_sclk, w_sclk_rise, w_sclk_fall;
    logic w_csn, w_csn_rise, w_csn_fall;
    logic w_unused_sclk;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .i_clk(iCLK), .i_rst(iRST), .i_async(iSPI_CLK),
        .o_level(w_sclk), .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
        .i_clk(iCLK), .i_rst(iRST), .i_async(iSPI_CSN),
        .o_level(w_csn), .o_rise_c(w_csn_rise), .o_fall_c(w_csn_fall)
    );

    assign w_unused_sclk = w_sclk;

    // SDI runs through the same depth so it lines up with the SCLK strobes.
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   w_sdi;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) r_sdi_sync <= '0;
        else      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], iSPI_SDI};
    end
    assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

    state_t            r_state;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_shift;
    logic [6:0]        r_tx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mb;
    logic              r_sdo, r_sdo_oe, r_int2;
    logic [7:0]        r_bw_rate, r_power_ctl, r_int_enable, r_int_map, r_data_format;
    logic [15:0]       r_snap_x, r_snap_y, r_snap_z;
    logic [15:0]       r_pend_x, r_pend_y, r_pend_z;
    logic              r_pend_vld, r_drdy;
    logic [7:0]        w_rd_byte, w_wr_byte;
    logic              w_is_data;

    assign w_wr_byte = {r_shift, w_sdi};
    assign w_is_data = (r_addr >= ADDR_DATAX0) && (r_addr <= ADDR_DATAZ1);

    always_comb begin
        w_rd_byte = 8'h00;
        case (r_addr)
            ADDR_DEVID:       w_rd_byte = DEVID_VAL;
            ADDR_BW_RATE:     w_rd_byte = r_bw_rate;
            ADDR_POWER_CTL:   w_rd_byte = r_power_ctl;
            ADDR_INT_ENABLE:  w_rd_byte = r_int_enable;
            ADDR_INT_MAP:     w_rd_byte = r_int_map;
            ADDR_INT_SOURCE:  w_rd_byte = {r_drdy, 7'b0};
            ADDR_DATA_FORMAT: w_rd_byte = r_data_format;
            ADDR_DATAX0:      w_rd_byte = r_snap_x[7:0];
            ADDR_DATAX1:      w_rd_byte = r_snap_x[15:8];
            ADDR_DATAY0:      w_rd_byte = r_snap_y[7:0];
            ADDR_DATAY1:      w_rd_byte = r_snap_y[15:8];
            ADDR_DATAZ0:      w_rd_byte = r_snap_z[7:0];
            ADDR_DATAZ1:      w_rd_byte = r_snap_z[15:8];
            default:          w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 7'd0;
            r_tx          <= 7'd0;
            r_addr        <= '0;
            r_mb          <= 1'b0;
            r_sdo         <= 1'b0;
            r_sdo_oe      <= 1'b0;
            r_int2        <= 1'b0;
            r_bw_rate     <= BW_RATE_RST;
            r_power_ctl   <= 8'h00;
            r_int_enable  <= 8'h00;
            r_int_map     <= 8'h00;
            r_data_format <= 8'h00;
            r_snap_x      <= 16'h0000;
            r_snap_y      <= 16'h0000;
            r_snap_z      <= 16'h0000;
            r_pend_x      <= 16'h0000;
            r_pend_y      <= 16'h0000;
            r_pend_z      <= 16'h0000;
            r_pend_vld    <= 1'b0;
            r_drdy        <= 1'b0;
        end else begin
            r_int2 <= r_drdy & r_int_enable[7] & r_int_map[7];

            if (w_csn_rise) begin
                r_state   <= ST_IDLE;
                r_sdo_oe  <= 1'b0;
                r_sdo     <= 1'b0;
                r_bit_cnt <= 3'd0;
                if (r_pend_vld) begin
                    r_snap_x   <= r_pend_x;
                    r_snap_y   <= r_pend_y;
                    r_snap_z   <= r_pend_z;
                    r_pend_vld <= 1'b0;
                    r_drdy     <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_csn_fall) begin
                            r_state   <= ST_CMD;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {r_shift[5:0], w_sdi};
                            if (r_bit_cnt == 3'd7) begin
                                r_mb    <= r_shift[5];
                                r_addr  <= {r_shift[4:0], w_sdi};
                                r_state <= r_shift[6] ? ST_RDATA : ST_WDATA;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {r_shift[5:0], w_sdi};
                            if (r_bit_cnt == 3'd7) begin
                                case (r_addr)
                                    ADDR_BW_RATE:     r_bw_rate     <= w_wr_byte;
                                    ADDR_POWER_CTL:   r_power_ctl   <= w_wr_byte;
                                    ADDR_INT_ENABLE:  r_int_enable  <= w_wr_byte;
                                    ADDR_INT_MAP:     r_int_map     <= w_wr_byte;
                                    ADDR_DATA_FORMAT: r_data_format <= w_wr_byte;
                                    default: ;
                                endcase
                                r_addr <= r_addr + ADDR_W'(r_mb);
                            end
                        end
                    end
                    ST_RDATA: begin
                        // Each byte is fetched when its MSB goes out on the pad.
                        if (w_sclk_fall) begin
                            r_sdo_oe  <= 1'b1;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd0) begin
                                r_sdo <= w_rd_byte[7];
                                r_tx  <= w_rd_byte[6:0];
                                if (w_is_data) r_drdy <= 1'b0;
                            end else begin
                                r_sdo <= r_tx[6];
                                r_tx  <= {r_tx[5:0], 1'b0};
                            end
                            if (r_bit_cnt == 3'd7) r_addr <= r_addr + ADDR_W'(r_mb);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            // A sample arriving mid-frame is parked so a burst never mixes samples.
            if (iSAMPLE_VLD) begin
                if (w_csn) begin
                    r_snap_x   <= iX_DATA;
                    r_snap_y   <= iY_DATA;
                    r_snap_z   <= iZ_DATA;
                    r_pend_vld <= 1'b0;
                    r_drdy     <= 1'b1;
                end else begin
                    r_pend_x   <= iX_DATA;
                    r_pend_y   <= iY_DATA;
                    r_pend_z   <= iZ_DATA;
                    r_pend_vld <= 1'b1;
                end
            end
        end
    end

    assign oSPI_SDO     = r_sdo;
    assign oSPI_SDO_OE  = r_sdo_oe;
    assign oINT2        = r_int2;
    assign oMEASURE     = r_power_ctl[3];
    assign oBW_RATE     = r_bw_rate;
    assign oDATA_FORMAT = r_data_format;

endmodule
